// File: rtl/demux_1_2_stream.sv
// Packet-aware 1:2 stream demultiplexer. The destination is latched on a packet's
// first beat; each output has its own one-deep register so the other side keeps draining.
module demux_1_2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic [7:0]       pkt_cnt0,
  output logic [7:0]       pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

  state_t           state_q, state_d;
  logic             target;
  logic             accept;
  logic [1:0]       valid_q;
  logic [1:0]       last_q;
  logic [1:0]       ready_w;
  logic [1:0]       load_w;
  logic [WIDTH-1:0] data_q [2];
  logic [7:0]       cnt_q  [2];

  assign ready_w = {out1_ready, out0_ready};

  always_comb begin
    target = 1'b0;
    case (state_q)
      IDLE:    target = in_sel;
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = 1'b0;
    endcase
    // Only the selected output's register may stall the input.
    in_ready = !valid_q[target] || ready_w[target];
    accept   = in_valid && in_ready;
    load_w   = {accept && target, accept && !target};

    state_d = state_q;
    if (accept) begin
      if (in_last)     state_d = IDLE;
      else if (target) state_d = ROUTE1;
      else             state_d = ROUTE0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[gi] <= 1'b0;
          last_q[gi]  <= 1'b0;
          data_q[gi]  <= '0;
          cnt_q[gi]   <= 8'd0;
        end else begin
          // A load takes priority over a drain so a full register streams 1 beat/cycle.
          if (load_w[gi]) begin
            valid_q[gi] <= 1'b1;
            last_q[gi]  <= in_last;
            data_q[gi]  <= in_data;
            if (in_last) cnt_q[gi] <= cnt_q[gi] + 8'd1;
          end else if (valid_q[gi] && ready_w[gi]) begin
            valid_q[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign out0_data  = data_q[0];
  assign out0_valid = valid_q[0];
  assign out0_last  = last_q[0];
  assign out1_data  = data_q[1];
  assign out1_valid = valid_q[1];
  assign out1_last  = last_q[1];
  assign pkt_cnt0   = cnt_q[0];
  assign pkt_cnt1   = cnt_q[1];

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Scoreboard bench for demux_1_2_stream: a routing model pushes expected beats per output,
// negedge monitors pop and compare them as the outputs hand off.
module tb_demux_1_2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_sel, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out0_last, out0_ready;
  logic       out1_valid, out1_last, out1_ready;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  demux_1_2_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel),
    .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Expected beats {last,data} per output, plus the bench's own routing model.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         m_state = 0;   // 0 idle, 1 route0, 2 route1
  logic [7:0] e_cnt0 = 8'd0;
  logic [7:0] e_cnt1 = 8'd0;

  logic       hold0_p = 1'b0, hold1_p = 1'b0;
  logic [8:0] hold0_v, hold1_v;

  always @(negedge clk) begin
    if (!rst_n) hold0_p = 1'b0;
    else begin
      if (hold0_p) check("hold0", 32'({out0_valid, out0_last, out0_data}), 32'({1'b1, hold0_v}));
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("extra0", 32'(q0.size()), 32'd1);
        else check("data0", 32'({out0_last, out0_data}), 32'(q0.pop_front()));
      end
      hold0_p = out0_valid && !out0_ready;
      hold0_v = {out0_last, out0_data};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold1_p = 1'b0;
    else begin
      if (hold1_p) check("hold1", 32'({out1_valid, out1_last, out1_data}), 32'({1'b1, hold1_v}));
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("extra1", 32'(q1.size()), 32'd1);
        else check("data1", 32'({out1_last, out1_data}), 32'(q1.pop_front()));
      end
      hold1_p = out1_valid && !out1_ready;
      hold1_v = {out1_last, out1_data};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic s);
    int   n = 0;
    bit   done = 0;
    logic tgt;
    in_valid = 1'b1; in_data = d; in_last = l; in_sel = s;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        tgt = (m_state == 0) ? s : (m_state == 2);
        if (tgt) q1.push_back({l, d}); else q0.push_back({l, d});
        if (l) begin
          if (tgt) e_cnt1 = e_cnt1 + 8'd1; else e_cnt0 = e_cnt0 + 8'd1;
          m_state = 0;
        end else begin
          m_state = tgt ? 2 : 1;
        end
        done = 1;
      end else if (++n > 200) begin
        check("accept_timeout", 32'(n), 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_v0"}, 32'(out0_valid), 32'd0);
    check({tag, "_v1"}, 32'(out1_valid), 32'd0);
    check({tag, "_c0"}, 32'(pkt_cnt0), 32'd0);
    check({tag, "_c1"}, 32'(pkt_cnt1), 32'd0);
    check({tag, "_d"},  32'({out0_last, out0_data, out1_last, out1_data}), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  // Asynchronous reset applied between edges; the model is cleared with it.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete();
    m_state = 0; e_cnt0 = 8'd0; e_cnt1 = 8'd0;
    reset_checks(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int c;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat route to out1
    send_beat(8'hA5, 1'b1, 1'b1);
    idle(0);
    check("single_v1", 32'({out1_valid, out1_last, out1_data}), 32'({1'b1, 1'b1, 8'hA5}));
    check("single_v0", 32'(out0_valid), 32'd0);
    check("single_cnt1", 32'(pkt_cnt1), 32'(e_cnt1));
    idle(2);

    // Select lock: in_sel changes mid-packet must be ignored
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h33, 1'b1, 1'b1);
    idle(2);
    check("lock_cnt0", 32'(pkt_cnt0), 32'(e_cnt0));
    check("lock_cnt1", 32'(pkt_cnt1), 32'(e_cnt1));

    // Backpressure on out0
    out0_ready = 1'b0;
    send_beat(8'h40, 1'b0, 1'b0);
    in_data = 8'h41; in_last = 1'b0; in_sel = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("bp_rdy", 32'(in_ready), 32'd0);
    check("bp_held", 32'({out0_valid, out0_data}), 32'({1'b1, 8'h40}));
    repeat (3) @(posedge clk);
    #1;
    out0_ready = 1'b1;
    c = cyc;
    send_beat(8'h41, 1'b0, 1'b1);
    send_beat(8'h42, 1'b0, 1'b1);
    send_beat(8'h43, 1'b1, 1'b1);
    check("bp_rate", 32'(cyc - c), 32'd3);
    idle(2);

    // Independent drain: out1 stalled while a packet flows to out0
    out1_ready = 1'b0;
    send_beat(8'hB7, 1'b1, 1'b1);
    c = cyc;
    send_beat(8'h51, 1'b0, 1'b0);
    send_beat(8'h52, 1'b0, 1'b1);
    send_beat(8'h53, 1'b1, 1'b1);
    check("indep_rate", 32'(cyc - c), 32'd3);
    idle(2);
    check("indep_held1", 32'({out1_valid, out1_last, out1_data}), 32'({1'b1, 1'b1, 8'hB7}));
    out1_ready = 1'b1;
    idle(2);
    check("indep_cnt0", 32'(pkt_cnt0), 32'(e_cnt0));

    // Counter wrap after 256 packets
    do_reset("rst2");
    for (int i = 0; i < 256; i++) begin
      send_beat(8'(i), 1'b1, 1'b0);
      if (i == 254) check("wrap_255", 32'(pkt_cnt0), 32'd255);
    end
    idle(2);
    check("wrap_cnt0", 32'(pkt_cnt0), 32'(e_cnt0));
    check("wrap_zero", 32'(pkt_cnt0), 32'd0);
    check("wrap_cnt1", 32'(pkt_cnt1), 32'(e_cnt1));

    // Mid-packet reset on a 4-beat out1 packet
    send_beat(8'h61, 1'b1, 1'b1);
    send_beat(8'h71, 1'b0, 1'b1);
    send_beat(8'h72, 1'b0, 1'b0);
    in_valid = 1'b0;
    do_reset("midrst");
    send_beat(8'h77, 1'b1, 1'b0);
    idle(0);
    check("post_rst_v0", 32'({out0_valid, out0_last, out0_data}), 32'({1'b1, 1'b1, 8'h77}));
    check("post_rst_v1", 32'(out1_valid), 32'd0);
    idle(3);
    check("post_rst_cnt0", 32'(pkt_cnt0), 32'(e_cnt0));
    check("post_rst_cnt1", 32'(pkt_cnt1), 32'(e_cnt1));

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1_2_stream.md
DEMUX_1_2_STREAM -- requirements
Module: demux_1_2_stream

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width in bits.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_data  input  WIDTH  input beat payload.
REQ-005 SHALL have ports: in_valid  input  1  input beat present.
REQ-006 SHALL have ports: in_last  input  1  final beat of packet.
REQ-007 SHALL have ports: in_sel  input  1  destination (0 -> out0, 1 -> out1), sampled on first beat only.
REQ-008 SHALL have ports: in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-009 SHALL have ports: out0_data/out1_data  output  WIDTH  registered payload.
REQ-010 SHALL have ports: out0_valid/out1_valid  output  1  output beat present.
REQ-011 SHALL have ports: out0_last/out1_last  output  1  registered in_last.
REQ-012 SHALL have ports: out0_ready/out1_ready  input  1  downstream accept.
REQ-013 SHALL have ports: pkt_cnt0/pkt_cnt1  output  8  completed packets routed to each output.

Function
REQ-014 SHALL implement FSM states IDLE, ROUTE0, ROUTE1.
REQ-015 SHALL define target: in IDLE = in_sel (combinational); in ROUTE0 = 0; in ROUTE1 = 1.
REQ-016 SHALL drive in_ready = !outT_valid | outT_ready for target T; the non-target output SHALL NOT gate in_ready.
REQ-017 On accept in IDLE with in_last=0, SHALL go to ROUTE(in_sel); with in_last=1 (single-beat packet), SHALL stay in IDLE.
REQ-018 In ROUTEx, SHALL ignore in_sel; on accept with in_last=1, SHALL return to IDLE; otherwise stay.
REQ-019 On accept, SHALL load outT_data/outT_last from in_data/in_last and set outT_valid=1 on the next edge (latency 1 cycle).
REQ-020 Output register x SHALL clear outx_valid when outx_valid & outx_ready and no load into x in that cycle; load with simultaneous drain SHALL keep valid=1 with the new data (full throughput, 1 beat/cycle).
REQ-021 outx_data/outx_last SHALL hold stable while outx_valid=1 and outx_ready=0.
REQ-022 Non-target output SHALL continue draining independently while the other is loaded.
REQ-023 pkt_cntx SHALL increment by 1 on each accepted beat with in_last=1 routed to x; wraps 255 -> 0.
REQ-024 in_valid=0 SHALL cause no state, register or counter change except output drains.
REQ-025 Beats within a packet SHALL never be split across outputs or reordered.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, out0_valid=out1_valid=0, out*_data=0, out*_last=0, pkt_cnt0=pkt_cnt1=0.
REQ-027 Reset asserted mid-packet SHALL discard the partial packet and held output beats; after release, the next accepted beat SHALL be treated as a first beat (in_sel sampled).
REQ-028 in_ready SHALL follow REQ-016 during reset (outputs empty, so in_ready=1).

Verification
REQ-029 Single-beat route: IDLE, in_sel=1, in_data=8'hA5, in_last=1, in_valid=1, out1_ready=1 -> next cycle out1_valid=1, out1_data=A5, out1_last=1; pkt_cnt1=1; out0_valid stays 0.
REQ-030 Select lock: 3-beat packet 11,22,33 with in_sel=0 on beat 1, toggled to 1 on beats 2-3 -> all three on out0 in order, out0_last only with 33; pkt_cnt0=1.
REQ-031 Backpressure: out0_ready=0, packet to out0 -> first beat held on out0 (data stable), in_ready=0 next cycle; out0_ready=1 -> remaining beats flow one per cycle with no loss.
REQ-032 Independent drain: out1 holds beat with out1_ready=0, new packet to out0 -> in_ready=1, out0 receives beats, out1 beat stays held unchanged.
REQ-033 Counter wrap: 256 single-beat packets to out0 -> pkt_cnt0 reads 0, pkt_cnt1 unchanged.
REQ-034 Mid-packet reset: assert rst_n=0 after beat 2 of a 4-beat packet to out1 -> all valids and counters 0 asynchronously; after release, in_sel=0 first beat routes to out0.
